pe_input_feeder: RTL and testbench

//  Upstream feeder for pe_with_maxpool. Accepts a valid/ready byte stream of image pixels.

---
 rtl/pe_input_feeder.sv | 139 +++++++++++++
 tb/tb_pe_input_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_input_feeder.sv
// rtl/pe_input_feeder.sv - skewed pixel feeder with walking start token for the PE array
// Lane i of img carries the pixel stream delayed by i advances; start marks pixel 0 per lane.
module pe_input_feeder #(
    parameter int IMG_ROW = 13,
    parameter int LEN_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [2:0]           cfg_channel,
    input  logic                 pix_valid,
    input  logic [7:0]           pix_data,
    output logic                 pix_ready,
    output logic [IMG_ROW*8-1:0] img,
    output logic [IMG_ROW-1:0]   start,
    output logic [IMG_ROW-1:0]   pe_reset,
    output logic [2:0]           channel_packed,
    output logic                 busy,
    output logic                 done
);

    localparam int DW = (IMG_ROW > 2) ? $clog2(IMG_ROW - 1) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(IMG_ROW - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     count_q, count_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [2:0]           channel_q, channel_d;
    logic [IMG_ROW*8-1:0] img_q, img_d;
    logic [IMG_ROW-1:0]   token_q, token_d;
    logic [IMG_ROW-1:0]   start_q, start_d;
    logic [IMG_ROW-1:0]   pe_reset_q, pe_reset_d;

    logic       beat;
    logic       advance;
    logic       first;
    logic [7:0] adv_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_CLEAR;
            S_CLEAR: state_d = (len_q == '0) ? S_DONE : S_RUN;
            S_RUN:   if (beat && (count_q == len_q - LEN_W'(1))) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pix_ready = (state_q == S_RUN);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
    end

    always_comb begin
        beat     = pix_valid && pix_ready;
        advance  = ((state_q == S_RUN) && beat) || (state_q == S_DRAIN);
        adv_byte = (state_q == S_RUN) ? pix_data : 8'h00;
        first    = (state_q == S_RUN) && (count_q == '0);

        len_d      = len_q;
        count_d    = count_q;
        channel_d  = channel_q;
        img_d      = img_q;
        token_d    = token_q;
        start_d    = '0;
        pe_reset_d = '0;
        drain_d    = (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;

        if ((state_q == S_IDLE) && go) begin
            len_d      = cfg_len;
            channel_d  = cfg_channel;
            count_d    = '0;
            token_d    = '0;
            pe_reset_d = '1;
        end
        if (state_q == S_CLEAR) begin
            img_d = '0;
        end
        // The token bit leaving the top lane is simply dropped.
        if (advance) begin
            img_d   = {img_q[IMG_ROW*8-9:0], adv_byte};
            token_d = {token_q[IMG_ROW-2:0], first};
            start_d = {token_q[IMG_ROW-2:0], first};
        end
        if ((state_q == S_RUN) && beat) begin
            count_d = count_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            count_q    <= '0;
            drain_q    <= '0;
            channel_q  <= '0;
            img_q      <= '0;
            token_q    <= '0;
            start_q    <= '0;
            pe_reset_q <= '0;
        end else begin
            len_q      <= len_d;
            count_q    <= count_d;
            drain_q    <= drain_d;
            channel_q  <= channel_d;
            img_q      <= img_d;
            token_q    <= token_d;
            start_q    <= start_d;
            pe_reset_q <= pe_reset_d;
        end
    end

    assign img            = img_q;
    assign start          = start_q;
    assign pe_reset       = pe_reset_q;
    assign channel_packed = channel_q;

endmodule

// File: tb/tb_pe_input_feeder.sv
// tb/tb_pe_input_feeder.sv - self-checking bench for pe_input_feeder
// Frame-level reference model: history queue of advanced bytes plus beat/drain budgets.
module tb_pe_input_feeder;

    localparam int IMG_ROW = 13;
    localparam int LEN_W   = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 go = 1'b0;
    logic [LEN_W-1:0]     cfg_len = '0;
    logic [2:0]           cfg_channel = '0;
    logic                 pix_valid = 1'b0;
    logic [7:0]           pix_data = '0;
    logic                 pix_ready;
    logic [IMG_ROW*8-1:0] img;
    logic [IMG_ROW-1:0]   start;
    logic [IMG_ROW-1:0]   pe_reset;
    logic [2:0]           channel_packed;
    logic                 busy;
    logic                 done;

    pe_input_feeder #(.IMG_ROW(IMG_ROW), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .go(go), .cfg_len(cfg_len), .cfg_channel(cfg_channel),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready), .img(img),
        .start(start), .pe_reset(pe_reset), .channel_packed(channel_packed),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit                 m_active, m_clear, m_done;
    int                 m_beats_left, m_drain_left, m_adv;
    logic [2:0]         m_chan;
    logic [7:0]         m_hist[$];
    logic [IMG_ROW-1:0] m_start, m_pe;

    function automatic bit m_ready();
        return m_active && !m_clear && !m_done && (m_beats_left > 0);
    endfunction

    task automatic model_step();
        bit         adv;
        logic [7:0] b;
        logic [IMG_ROW-1:0] one;
        one = 1;
        if (reset) begin
            m_active = 0; m_clear = 0; m_done = 0;
            m_beats_left = 0; m_drain_left = 0; m_adv = 0;
            m_chan = 0; m_hist.delete(); m_start = 0; m_pe = 0;
            return;
        end
        adv = 0; b = 0;
        if (m_ready() && pix_valid) begin
            adv = 1; b = pix_data;
        end else if (m_active && !m_clear && !m_done && m_beats_left == 0 && m_drain_left > 0) begin
            adv = 1;
        end
        m_pe = 0;
        m_start = 0;
        if (m_clear) m_hist.delete();
        if (adv) begin
            m_hist.push_front(b);
            if (m_hist.size() > IMG_ROW) void'(m_hist.pop_back());
            m_adv++;
            if (m_adv <= IMG_ROW) m_start = one << (m_adv - 1);
        end
        if (!m_active) begin
            if (go) begin
                m_active = 1; m_clear = 1; m_beats_left = int'(cfg_len);
                m_drain_left = IMG_ROW - 1; m_adv = 0; m_chan = cfg_channel; m_pe = '1;
            end
        end else if (m_done) begin
            m_active = 0; m_done = 0;
        end else if (m_clear) begin
            m_clear = 0;
            if (m_beats_left == 0) m_done = 1;
        end else if (m_beats_left > 0) begin
            if (adv) m_beats_left--;
        end else begin
            m_drain_left--;
            if (m_drain_left == 0) m_done = 1;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        logic [IMG_ROW*8-1:0] exp_img;
        exp_img = '0;
        for (int i = 0; i < IMG_ROW; i++)
            if (i < m_hist.size()) exp_img[i*8 +: 8] = m_hist[i];
        chk("m_img", 128'(img), 128'(exp_img));
        chk("m_start", 128'(start), 128'(m_start));
        chk("m_pe_reset", 128'(pe_reset), 128'(m_pe));
        chk("m_channel", 128'(channel_packed), 128'(m_chan));
        chk("m_busy", 128'(busy), 128'(m_active));
        chk("m_done", 128'(done), 128'(m_done));
        chk("m_pix_ready", 128'(pix_ready), 128'(m_ready()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_done(input int from, input int max, output int n);
        n = -1;
        for (int i = from + 1; i <= max; i++) begin
            tick();
            if (done) begin
                n = i;
                return;
            end
        end
    endtask

    typedef struct {
        logic               go;
        logic               valid;
        logic [7:0]         data;
        logic [7:0]         lane0;
        logic [IMG_ROW-1:0] st;
        logic [IMG_ROW-1:0] per;
        logic               dn;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int n;
        vecs[0]  = '{1, 1, 8'h01, 8'h00, 13'h0000, 13'h1FFF, 0};
        vecs[1]  = '{0, 1, 8'h01, 8'h00, 13'h0000, 13'h0000, 0};
        vecs[2]  = '{0, 1, 8'h01, 8'h01, 13'h0001, 13'h0000, 0};
        vecs[3]  = '{0, 1, 8'h02, 8'h02, 13'h0002, 13'h0000, 0};
        vecs[4]  = '{0, 1, 8'h03, 8'h03, 13'h0004, 13'h0000, 0};
        vecs[5]  = '{0, 1, 8'h04, 8'h04, 13'h0008, 13'h0000, 0};
        vecs[6]  = '{0, 0, 8'h00, 8'h00, 13'h0010, 13'h0000, 0};
        vecs[7]  = '{0, 0, 8'h00, 8'h00, 13'h0020, 13'h0000, 0};
        vecs[8]  = '{0, 0, 8'h00, 8'h00, 13'h0040, 13'h0000, 0};
        vecs[9]  = '{0, 0, 8'h00, 8'h00, 13'h0080, 13'h0000, 0};
        vecs[10] = '{0, 0, 8'h00, 8'h00, 13'h0100, 13'h0000, 0};
        vecs[11] = '{0, 0, 8'h00, 8'h00, 13'h0200, 13'h0000, 0};
        vecs[12] = '{0, 0, 8'h00, 8'h00, 13'h0400, 13'h0000, 0};
        vecs[13] = '{0, 0, 8'h00, 8'h00, 13'h0800, 13'h0000, 0};
        vecs[14] = '{0, 0, 8'h00, 8'h00, 13'h1000, 13'h0000, 0};
        vecs[15] = '{0, 0, 8'h00, 8'h00, 13'h0000, 13'h0000, 0};
        vecs[16] = '{0, 0, 8'h00, 8'h00, 13'h0000, 13'h0000, 0};
        vecs[17] = '{0, 0, 8'h00, 8'h00, 13'h0000, 13'h0000, 1};
        vecs[18] = '{0, 0, 8'h00, 8'h00, 13'h0000, 13'h0000, 0};

        // Reset held with go and pix_valid asserted
        reset = 1; go = 1; pix_valid = 1; pix_data = 8'h55; cfg_len = 8'd4; cfg_channel = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_img", 128'(img), 128'(0));
            chk("rst_ready", 128'(pix_ready), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
        end
        reset = 0; go = 0; pix_valid = 0;
        tick();

        // Table-driven no-stall frame, len=4 channel=2
        cfg_len = 8'd4; cfg_channel = 3'b010;
        for (int i = 0; i < 19; i++) begin
            go = vecs[i].go; pix_valid = vecs[i].valid; pix_data = vecs[i].data;
            tick();
            chk($sformatf("t2_lane0[%0d]", i), 128'(img[7:0]), 128'(vecs[i].lane0));
            chk($sformatf("t2_start[%0d]", i), 128'(start), 128'(vecs[i].st));
            chk($sformatf("t2_pe_reset[%0d]", i), 128'(pe_reset), 128'(vecs[i].per));
            chk($sformatf("t2_done[%0d]", i), 128'(done), 128'(vecs[i].dn));
        end
        chk("t2_channel", 128'(channel_packed), 128'(3'b010));
        chk("t2_idle", 128'(busy), 128'(0));

        // Bubble of 3 cycles after beat 1
        go = 1; pix_valid = 1; pix_data = 8'h01;
        tick();
        go = 0;
        tick();
        tick();
        pix_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_bubble_start", 128'(start), 128'(0));
            chk("t3_bubble_lane0", 128'(img[7:0]), 128'(8'h01));
        end
        pix_valid = 1;
        for (int i = 2; i <= 4; i++) begin
            pix_data = 8'(i);
            tick();
        end
        pix_valid = 0;
        wait_done(8, 40, n);
        chk("t3_done_cycle", 128'(n), 128'(20));
        tick();

        // len=0: CLEAR then DONE
        cfg_len = 0; go = 1;
        tick();
        go = 0;
        chk("t4_pe_reset", 128'(pe_reset), 128'(13'h1FFF));
        tick();
        chk("t4_done", 128'(done), 128'(1));
        chk("t4_start", 128'(start), 128'(0));
        tick();
        chk("t4_idle", 128'(busy), 128'(0));

        // go during RUN with another channel is ignored
        cfg_len = 4; cfg_channel = 3'b010; go = 1; pix_valid = 1; pix_data = 8'h11;
        tick();
        go = 0;
        tick();
        cfg_channel = 3'b101; go = 1;
        tick();
        go = 0;
        chk("t5_channel_run", 128'(channel_packed), 128'(3'b010));
        wait_done(2, 40, n);
        chk("t5_done_cycle", 128'(n), 128'(17));
        tick();
        chk("t5_channel_after", 128'(channel_packed), 128'(3'b010));

        // Reset during DRAIN, then a len=1 frame
        cfg_len = 4; cfg_channel = 3'b010; go = 1; pix_valid = 1;
        tick();
        go = 0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1;
        tick();
        chk("t6_img", 128'(img), 128'(0));
        chk("t6_start", 128'(start), 128'(0));
        chk("t6_done", 128'(done), 128'(0));
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_channel", 128'(channel_packed), 128'(0));
        reset = 0;
        tick();
        cfg_len = 1; pix_data = 8'hAB; go = 1;
        tick();
        go = 0;
        wait_done(0, 40, n);
        chk("t6_len1_done_cycle", 128'(n), 128'(14));
        tick();

        // Randomized traffic against the model
        for (int f = 0; f < 30; f++) begin
            for (int c = 0; c < 60; c++) begin
                go          = ($urandom_range(0, 99) < 15);
                cfg_len     = 8'($urandom_range(0, 15));
                cfg_channel = 3'($urandom);
                pix_valid   = ($urandom_range(0, 9) < 7);
                pix_data    = 8'($urandom);
                reset       = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        reset = 0; go = 0; pix_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
